// File: rtl/mvu_dma_sched_pkg.sv
// Shared definitions for the MVU DMA descriptor scheduler: FSM encoding,
// descriptor layout {role, size, dst, src} and the watchdog limit.
package mvu_dma_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } sched_state_e;

  localparam int DEF_AW = 32;
  localparam int DEF_SW = 16;
  localparam int ROLE_W = 1;

  localparam logic [15:0] WD_LIMIT = 16'hFFFF;

  // Packed descriptor is {role, size, dst, src}, src in the low bits.
  function automatic int desc_width(input int aw, input int sw);
    return 2 * aw + sw + ROLE_W;
  endfunction

endpackage

// File: rtl/mvu_dma_desc_fifo.sv
// Descriptor FIFO: register-array storage, head visible combinationally,
// flush empties it and discards any push in the same cycle.
module mvu_dma_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 81
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == PW'(gi)))
          mem_reg[gi] <= wdata;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mvu_dma_sched.sv
// Descriptor-queue scheduler feeding the MVU DMA core, one transfer at a time.
// Optional watchdog and sched_timeout port: define MVU_DMA_SCHED_TIMEOUT_EN.
module mvu_dma_sched
  import mvu_dma_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = DEF_AW,
  parameter int SW    = DEF_SW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [AW-1:0]            desc_src,
  input  logic [AW-1:0]            desc_dst,
  input  logic [SW-1:0]            desc_size,
  input  logic                     desc_role,
  input  logic                     sched_en,
  input  logic                     flush,
  output logic [AW-1:0]            dma_source_addr_o,
  output logic [AW-1:0]            dma_dest_addr_o,
  output logic [SW-1:0]            dma_transfer_size_o,
  output logic                     dma_transfer_role_o,
  output logic                     dma_transfer_start_o,
  input  logic [31:0]              dma_status_i,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     sched_busy,
  output logic [15:0]              done_cnt,
  output logic                     sched_irq
`ifdef MVU_DMA_SCHED_TIMEOUT_EN
  , output logic                   sched_timeout
`endif
);
  localparam int DW = desc_width(AW, SW);
  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_e  state_reg, state_next;
  logic [DW-1:0] head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          push_acc, pop_req, zero_drop, launch, busy_bit, done_now, q_empty_next;
  logic [AW-1:0] src_reg, dst_reg;
  logic [SW-1:0] size_reg;
  logic          role_reg;
  logic [15:0]   done_cnt_reg;
  logic          status_unused;

  assign status_unused = ^dma_status_i[31:1];
  assign busy_bit      = dma_status_i[0];

  assign desc_ready = (fifo_count != CW'(DEPTH));
  assign push_acc   = desc_valid && desc_ready && !flush;
  assign pop_req    = (state_reg == S_IDLE) && sched_en && !fifo_empty && !flush;
  assign zero_drop  = pop_req && (head[2*AW +: SW] == '0);
  assign launch     = pop_req && !zero_drop;
  assign done_now   = (state_reg == S_WAIT_DONE) && !busy_bit;

  // Queue occupancy after this edge is zero: nothing left to schedule.
  assign q_empty_next = flush || (!push_acc && (fifo_count == {{(CW-1){1'b0}}, pop_req}));

  mvu_dma_desc_fifo #(.DEPTH(DEPTH), .W(DW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_acc),
    .pop   (pop_req),
    .flush (flush),
    .wdata ({desc_role, desc_size, desc_dst, desc_src}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MVU_DMA_SCHED_TIMEOUT_EN
  logic [15:0] wd_reg;
  logic        wd_hit;
  logic        in_wait;

  assign in_wait       = (state_reg == S_WAIT_BUSY) || (state_reg == S_WAIT_DONE);
  assign wd_hit        = in_wait && (wd_reg == WD_LIMIT) && !done_now;
  assign sched_timeout = wd_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wd_reg <= '0;
    else if (state_next == S_START) wd_reg <= '0;
    else if (in_wait)               wd_reg <= wd_reg + 16'd1;
  end
`else
  logic wd_hit;
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (launch) state_next = S_LOAD;
      S_LOAD:      state_next = S_START;
      S_START:     state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (busy_bit) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!busy_bit) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (wd_hit) state_next = S_IDLE;
  end

  always_comb begin
    dma_transfer_start_o = (state_reg == S_START);
    sched_busy           = (state_reg != S_IDLE);
    sched_irq            = (done_now || zero_drop) && q_empty_next;
  end

  // Config registers only change on a launch, so the core sees them stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg      <= '0;
      dst_reg      <= '0;
      size_reg     <= '0;
      role_reg     <= 1'b0;
      done_cnt_reg <= '0;
    end else begin
      if (launch) begin
        src_reg  <= head[0 +: AW];
        dst_reg  <= head[AW +: AW];
        size_reg <= head[2*AW +: SW];
        role_reg <= head[DW-1];
      end
      if (done_now || zero_drop) done_cnt_reg <= done_cnt_reg + 16'd1;
    end
  end

  assign dma_source_addr_o   = src_reg;
  assign dma_dest_addr_o     = dst_reg;
  assign dma_transfer_size_o = size_reg;
  assign dma_transfer_role_o = role_reg;
  assign queue_count         = fifo_count;
  assign done_cnt            = done_cnt_reg;

endmodule

// File: tb/tb_mvu_dma_sched.sv
// Self-checking bench for mvu_dma_sched: scripted table, directed corner cases
// and a randomized run against a queue-based reference model.
module tb_mvu_dma_sched;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int SW    = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 desc_valid, desc_ready, desc_role, sched_en, flush;
  logic [AW-1:0]        desc_src, desc_dst;
  logic [SW-1:0]        desc_size;
  logic [AW-1:0]        dma_source_addr_o, dma_dest_addr_o;
  logic [SW-1:0]        dma_transfer_size_o;
  logic                 dma_transfer_role_o, dma_transfer_start_o;
  logic [31:0]          dma_status_i;
  logic [$clog2(DEPTH):0] queue_count;
  logic                 sched_busy, sched_irq;
  logic [15:0]          done_cnt;
`ifdef MVU_DMA_SCHED_TIMEOUT_EN
  logic                 sched_timeout;
`endif

  always #5 clk = ~clk;

  mvu_dma_sched #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .desc_valid           (desc_valid),
    .desc_ready           (desc_ready),
    .desc_src             (desc_src),
    .desc_dst             (desc_dst),
    .desc_size            (desc_size),
    .desc_role            (desc_role),
    .sched_en             (sched_en),
    .flush                (flush),
    .dma_source_addr_o    (dma_source_addr_o),
    .dma_dest_addr_o      (dma_dest_addr_o),
    .dma_transfer_size_o  (dma_transfer_size_o),
    .dma_transfer_role_o  (dma_transfer_role_o),
    .dma_transfer_start_o (dma_transfer_start_o),
    .dma_status_i         (dma_status_i),
    .queue_count          (queue_count),
    .sched_busy           (sched_busy),
    .done_cnt             (done_cnt),
    .sched_irq            (sched_irq)
`ifdef MVU_DMA_SCHED_TIMEOUT_EN
    , .sched_timeout      (sched_timeout)
`endif
  );

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [SW-1:0] size;
    logic          role;
  } desc_t;

  typedef struct {
    bit v; bit en; bit st;
    int cnt; bit busy; bit start; bit irq; int done;
  } vec_t;

  // Reference model: pending queue plus the descriptor in flight and its age.
  desc_t       mq[$];
  desc_t       last_cfg;
  bit          m_inflight, m_seen_busy;
  int          m_age;
  logic [15:0] m_done;

  int tests = 0, fails = 0;
  int starts_seen = 0, irq_seen = 0;
  bit core_armed;
  int core_wait, core_len;

  function automatic desc_t mk(input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input logic [SW-1:0] z, input logic r);
    desc_t x;
    x.src = s; x.dst = d; x.size = z; x.role = r;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last_cfg = mk('0, '0, '0, 1'b0);
    m_inflight = 0; m_seen_busy = 0; m_age = 0; m_done = '0;
    core_armed = 0; core_wait = 0; core_len = 0;
  endtask

  task automatic model_check();
    int    sz, nsz;
    bit    st0, done_now, pop, zdrop, push_acc, exp_irq;
    desc_t head;
    sz  = mq.size();
    st0 = dma_status_i[0];
    head = (sz > 0) ? mq[0] : mk('0, '0, '0, 1'b0);
    chk("queue_count", 64'(queue_count), 64'(sz));
    chk("desc_ready", 64'(desc_ready), 64'(sz != DEPTH));
    chk("sched_busy", 64'(sched_busy), 64'(m_inflight));
    chk("start", 64'(dma_transfer_start_o), 64'(m_inflight && m_age == 1));
    chk("done_cnt", 64'(done_cnt), 64'(m_done));
    chk("cfg_src", 64'(dma_source_addr_o), 64'(last_cfg.src));
    chk("cfg_dst", 64'(dma_dest_addr_o), 64'(last_cfg.dst));
    chk("cfg_size_role", 64'({dma_transfer_size_o, dma_transfer_role_o}),
        64'({last_cfg.size, last_cfg.role}));
    done_now = m_inflight && m_seen_busy && !st0;
    pop      = !m_inflight && sched_en && sz > 0 && !flush;
    zdrop    = pop && head.size == 0;
    push_acc = desc_valid && sz != DEPTH && !flush;
    nsz      = flush ? 0 : sz - int'(pop) + int'(push_acc);
    exp_irq  = (done_now || zdrop) && nsz == 0;
    chk("sched_irq", 64'(sched_irq), 64'(exp_irq));
    if (sched_irq) irq_seen++;
    if (dma_transfer_start_o) begin
      starts_seen++;
      $display("[TB] launch src=0x%0h dst=0x%0h size=%0d role=%0d done_cnt=%0d",
               dma_source_addr_o, dma_dest_addr_o, dma_transfer_size_o,
               dma_transfer_role_o, done_cnt);
      core_armed = 1;
      core_wait  = $urandom_range(0, 2);
      core_len   = $urandom_range(1, 6);
    end
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push_acc) mq.push_back(mk(desc_src, desc_dst, desc_size, desc_role));
    end
    if (done_now) begin
      m_inflight = 0;
      m_done++;
    end else if (m_inflight) begin
      if (m_age >= 2 && st0) m_seen_busy = 1;
      if (m_age < 1000) m_age++;
    end
    if (zdrop) m_done++;
    else if (pop) begin
      m_inflight = 1; m_age = 0; m_seen_busy = 0; last_cfg = head;
    end
  endtask

  // st_mode: -1 = reactive core model, 0/1 = forced busy bit.
  task automatic cycle(input bit v, input desc_t d, input bit en, input bit fl, input int st_mode);
    logic [31:0] r;
    bit st0;
    @(posedge clk); #1;
    desc_valid = v; desc_src = d.src; desc_dst = d.dst; desc_size = d.size; desc_role = d.role;
    sched_en = en; flush = fl;
    st0 = 1'b0;
    if (st_mode >= 0) st0 = st_mode[0];
    else if (core_armed) begin
      if (core_wait > 0) core_wait--;
      else if (core_len > 0) begin
        st0 = 1'b1;
        core_len--;
        if (core_len == 0) core_armed = 0;
      end
    end
    r = $urandom();
    dma_status_i = {r[31:1], st0};
    @(negedge clk);
    model_check();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_inflight || mq.size() != 0) && n < budget) begin
      cycle(1'b0, mk('0, '0, '0, 1'b0), 1'b1, 1'b0, -1);
      n++;
    end
    tests++;
    if (m_inflight || mq.size() != 0) begin
      fails++;
      $display("FAIL drain_budget: queue=%0d inflight=%0d after %0d cycles, expected empty",
               mq.size(), m_inflight, n);
    end
  endtask

  desc_t nul;
  vec_t  tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, s0;
    nul = mk('0, '0, '0, 1'b0);
    tbl[0]  = '{1,1,0, 0,0,0,0,0};
    tbl[1]  = '{0,1,0, 1,0,0,0,0};
    tbl[2]  = '{0,1,0, 0,1,0,0,0};
    tbl[3]  = '{0,1,0, 0,1,1,0,0};
    for (int i = 4; i < 10; i++) tbl[i] = '{0,1,1, 0,1,0,0,0};
    tbl[10] = '{0,1,0, 0,1,0,1,0};
    tbl[11] = '{0,1,0, 0,0,0,0,1};

    rst_n = 1'b0; desc_valid = 0; desc_src = '0; desc_dst = '0; desc_size = '0; desc_role = 0;
    sched_en = 0; flush = 0; dma_status_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_queue_count", 64'(queue_count), 64'd0);
    chk("rst_desc_ready", 64'(desc_ready), 64'd1);
    chk("rst_busy_start_irq", 64'({sched_busy, dma_transfer_start_o, sched_irq}), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_cfg", 64'(dma_source_addr_o | dma_dest_addr_o), 64'd0);
    rst_n = 1'b1;

    // Single descriptor, busy for 6 cycles.
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, mk(32'h100, 32'h10, 16'd1, 1'b0), tbl[i].en, 1'b0, int'(tbl[i].st));
      chk($sformatf("tbl%0d_count", i), 64'(queue_count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_busy", i), 64'(sched_busy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d_start", i), 64'(dma_transfer_start_o), 64'(tbl[i].start));
      chk($sformatf("tbl%0d_irq", i), 64'(sched_irq), 64'(tbl[i].irq));
      chk($sformatf("tbl%0d_done", i), 64'(done_cnt), 64'(tbl[i].done));
    end
    core_armed = 0;

    // Fill with scheduling disabled; fifth push refused.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, mk(32'h1000 + 32'(i), 32'h2000 + 32'(i), 16'(i + 2), 1'(i)), 1'b0, 1'b0, -1);
    chk("fill_queue_count", 64'(queue_count), 64'd4);
    chk("fill_desc_ready", 64'(desc_ready), 64'd0);
    d0 = int'(done_cnt); s0 = starts_seen; irq_seen = 0;
    drain(400);
    cycle(1'b0, nul, 1'b1, 1'b0, -1);
    chk("fill_done_delta", 64'(int'(done_cnt) - d0), 64'd4);
    chk("fill_starts", 64'(starts_seen - s0), 64'd4);
    chk("fill_irq_count", 64'(irq_seen), 64'd1);

    // Zero-size descriptor between two real ones.
    cycle(1'b1, mk(32'h300, 32'h400, 16'd3, 1'b1), 1'b0, 1'b0, -1);
    cycle(1'b1, mk(32'h310, 32'h410, 16'd0, 1'b0), 1'b0, 1'b0, -1);
    cycle(1'b1, mk(32'h320, 32'h420, 16'd2, 1'b0), 1'b0, 1'b0, -1);
    d0 = int'(done_cnt); s0 = starts_seen;
    drain(400);
    cycle(1'b0, nul, 1'b1, 1'b0, -1);
    chk("zero_done_delta", 64'(int'(done_cnt) - d0), 64'd3);
    chk("zero_starts", 64'(starts_seen - s0), 64'd2);

    // Flush while one transfer is in flight and two are queued.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, mk(32'h500 + 32'(i), 32'h600, 16'd4, 1'b0), 1'b0, 1'b0, -1);
    d0 = int'(done_cnt); s0 = starts_seen;
    cycle(1'b0, nul, 1'b1, 1'b0, -1);
    cycle(1'b0, nul, 1'b1, 1'b1, -1);
    chk("flush_queue_count", 64'(queue_count), 64'd2);
    drain(400);
    repeat (4) cycle(1'b0, nul, 1'b1, 1'b0, -1);
    chk("flush_queue_empty", 64'(queue_count), 64'd0);
    chk("flush_done_delta", 64'(int'(done_cnt) - d0), 64'd1);
    chk("flush_starts", 64'(starts_seen - s0), 64'd1);

    // Async reset in the middle of S_WAIT_DONE with descriptors queued.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, mk(32'h700 + 32'(i), 32'h800, 16'd5, 1'b1), 1'b0, 1'b0, 0);
    cycle(1'b0, nul, 1'b1, 1'b0, 0);
    cycle(1'b0, nul, 1'b1, 1'b0, 0);
    cycle(1'b0, nul, 1'b1, 1'b0, 0);
    cycle(1'b0, nul, 1'b1, 1'b0, 1);
    cycle(1'b0, nul, 1'b1, 1'b0, 1);
    chk("pre_rst_busy", 64'(sched_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_queue_count", 64'(queue_count), 64'd0);
    chk("arst_busy_start_irq", 64'({sched_busy, dma_transfer_start_o, sched_irq}), 64'd0);
    chk("arst_done_cnt", 64'(done_cnt), 64'd0);
    chk("arst_cfg", 64'({dma_source_addr_o, dma_dest_addr_o}), 64'd0);
    chk("arst_cfg_size_role", 64'({dma_transfer_size_o, dma_transfer_role_o}), 64'd0);
    chk("arst_desc_ready", 64'(desc_ready), 64'd1);
    model_reset();
    desc_valid = 0; sched_en = 0; dma_status_i = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      desc_t d;
      d = mk($urandom(), $urandom(),
             ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 500)),
             1'($urandom_range(0, 1)));
      cycle($urandom_range(0, 1) == 1, d, $urandom_range(0, 4) != 0,
            $urandom_range(0, 32) == 0, -1);
    end
    drain(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mvu_dma_sched.md
Name: mvu_dma_sched

Overview:
Descriptor-queue scheduler that sequences back-to-back transfers through the MVU DMA core. The CPU-side register block pushes transfer descriptors (source, destination, size, role) into an internal FIFO. The scheduler pops them one at a time, holds the core's configuration inputs stable, issues a one-cycle start pulse, and tracks the core's busy status until completion. It raises its own interrupt when the queue drains, so software is not interrupted per transfer.

Parameters:
DEPTH, 4, descriptor FIFO entries (power of 2, >=2)
AW, 32, source/destination address width
SW, 16, transfer size width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
desc_valid  in  1  descriptor push request
desc_ready  out  1  FIFO not full
desc_src  in  AW  source address
desc_dst  in  AW  destination address
desc_size  in  SW  transfer size (write beats)
desc_role  in  1  0=data, 1=weight
sched_en  in  1  allow pops/launches
flush  in  1  one-cycle pulse: drop all queued, not-yet-launched descriptors
dma_source_addr_o  out  AW  to core dma_source_addr_i
dma_dest_addr_o  out  AW  to core dma_dest_addr_i
dma_transfer_size_o  out  SW  to core dma_transfer_size_i
dma_transfer_role_o  out  1  to core dma_transfer_role_i
dma_transfer_start_o  out  1  to core dma_transfer_start_i
dma_status_i  in  32  from core; bit0=busy
queue_count  out  $clog2(DEPTH)+1  queued descriptors
sched_busy  out  1  descriptor in flight
done_cnt  out  16  completed descriptors, wraps at 0xFFFF->0
sched_irq  out  1  one-cycle pulse on queue drained

Behaviour:
- Reset (async, rst_n low): FIFO empty, FSM=S_IDLE, all outputs 0, desc_ready=1 (queue empty), done_cnt=0.
- Push accepted when desc_valid && desc_ready. desc_ready = (queue_count != DEPTH). A simultaneous push and pop is legal when full: desc_ready stays 0 that cycle; no write-through.
- FSM states:
  - S_IDLE: if sched_en && FIFO non-empty, pop the head and latch it into config registers -> S_LOAD. A popped descriptor with size==0 is dropped instead: done_cnt+1, stay in S_IDLE, never launched.
  - S_LOAD: config outputs are valid; start=0 -> S_START. Gives one cycle of setup before start.
  - S_START: dma_transfer_start_o=1 for exactly this cycle -> S_WAIT_BUSY.
  - S_WAIT_BUSY: wait for dma_status_i[0]==1 -> S_WAIT_DONE.
  - S_WAIT_DONE: wait for dma_status_i[0]==0; then done_cnt+1 -> S_IDLE.
- Config outputs hold the latched descriptor unchanged from S_LOAD through S_WAIT_DONE; the core reads size and role throughout the transfer. In S_IDLE they retain their last value.
- sched_busy = FSM != S_IDLE.
- Launch rate: the earliest next launch is 1 cycle after the return to S_IDLE (pop), with start 2 cycles after that.
- sched_irq: one-cycle pulse on the cycle the FSM leaves S_WAIT_DONE with the FIFO empty and no push accepted that cycle. Zero-size drops that empty the queue also pulse it.
- sched_en=0: no new pop. An in-flight transfer runs to completion.
- flush: empties the FIFO the same cycle. It does not abort the in-flight transfer, since the core has no abort. flush wins over a simultaneous push: the pushed descriptor is discarded. done_cnt is unchanged by flush.
- dma_status_i bits[31:1] are ignored.

Optional Feature:
MVU_DMA_SCHED_TIMEOUT_EN:
- When defined, a 16-bit watchdog counts cycles in S_WAIT_BUSY and S_WAIT_DONE.
- At 0xFFFF the FSM returns to S_IDLE without incrementing done_cnt, and the extra output port sched_timeout (1 bit) pulses for one cycle.
- The watchdog clears on every transition into S_START.
- When undefined, there is no watchdog, no port, and the FSM waits indefinitely.

Decomposition:
- Package mvu_dma_sched_pkg:
  - FSM state encodings (S_IDLE=3'd0, S_LOAD=3'd1, S_START=3'd2, S_WAIT_BUSY=3'd3, S_WAIT_DONE=3'd4)
  - descriptor field widths
  - descriptor struct/concat layout {role, size, dst, src}
  - watchdog limit
- One sub-module: mvu_dma_desc_fifo, a synchronous FIFO of width 2*AW+SW+1 with push/pop/flush and count.

Test Plan:
- Single descriptor (src=0x100, dst=0x10, size=1, role=0), core model busy for 6 cycles -> config outputs stable in S_LOAD..S_WAIT_DONE, start high exactly 1 cycle, done_cnt=1, sched_irq pulses once.
- Push 4 descriptors while sched_en=0 -> queue_count=4, desc_ready=0, fifth push refused. Then set sched_en=1 -> the 4 transfers are launched in order, done_cnt=4, exactly one sched_irq after the last.
- Descriptor with size=0 between two valid ones -> only 2 start pulses, done_cnt=3.
- flush while transfer 1 is in flight and 2 are queued -> transfer 1 completes, queue_count=0, done_cnt=1, no further starts.
- Assert rst_n low mid S_WAIT_DONE -> all outputs 0 immediately (async), queue empty, FSM S_IDLE.
- With MVU_DMA_SCHED_TIMEOUT_EN, hold dma_status_i[0]=1 forever -> sched_timeout pulses after 65535 wait cycles, done_cnt unchanged, next descriptor launches.
